// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the EX stage and mul_div_unit
//
// Purpose: groups the MULT/DIV request and the HI/LO result signals.
// Signals:
//   start, op, dataA, dataB : request from the pipeline (master -> slave)
//   busy, done, hi, lo      : status and HI/LO result (slave -> master)
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, dataA, dataB, input busy, done, hi, lo);
  modport slave  (input start, op, dataA, dataB, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle shift-add multiplier / restoring divider with HI/LO
//
// Purpose: EX-stage MULT/DIV unit. A start in IDLE latches the operands; one
//   preparation cycle loads the working accumulator, WIDTH iteration cycles
//   follow, and the FIN cycle pulses done while presenting the new HI/LO.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mul_div_unit_if.slave (start/op/dataA/dataB in, busy/done/hi/lo out)
// Configuration macro: SIGNED_MULDIV_EN (op[1] selects signed MULT/DIV when defined;
//   otherwise op[1] is ignored and only the unsigned core is built).
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               div_q, div_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step, res;

`ifdef SIGNED_MULDIV_EN
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  assign mag_a = neg_a_q ? -a_q : a_q;
  assign mag_b = neg_b_q ? -b_q : b_q;

  // Sign fix-up of the unsigned core result, applied combinationally in FIN.
  // A zero divisor keeps the raw all-ones quotient.
  always_comb begin
    res = acc_q;
    if (div_q) begin
      if (neg_a_q) res[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
      if ((neg_a_q ^ neg_b_q) && (b_q != '0)) res[WIDTH-1:0] = -acc_q[WIDTH-1:0];
    end else if (neg_a_q ^ neg_b_q) begin
      res = -acc_q;
    end
  end
`else
  logic unused_op1;
  assign unused_op1 = bus.op[1];
  assign mag_a      = a_q;
  assign mag_b      = b_q;
  assign res        = acc_q;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand into the upper half when the current multiplier bit is set,
  // then shift right (the carry lands in the top bit).
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  // div_trial[WIDTH] set means the trial subtraction borrowed -> restore.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
  assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef SIGNED_MULDIV_EN
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = bus.op[0] ? S_DIV : S_MUL;
          div_d   = bus.op[0];
          a_d     = bus.dataA;
          b_d     = bus.dataB;
          cnt_d   = '0;
`ifdef SIGNED_MULDIV_EN
          neg_a_d = bus.op[1] & bus.dataA[WIDTH-1];
          neg_b_d = bus.op[1] & bus.dataB[WIDTH-1];
`endif
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          // Preparation cycle: operands become magnitudes, accumulator is seeded
          // with the multiplier (MUL) or the dividend (DIV).
          a_d   = mag_a;
          b_d   = mag_b;
          acc_d = {{WIDTH{1'b0}}, ((state_q == S_MUL) ? mag_b : mag_a)};
        end else begin
          acc_d = (state_q == S_MUL) ? mul_step : div_step;
          if (cnt_q == CW'(WIDTH)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        hi_d    = res[2*WIDTH-1:WIDTH];
        lo_d    = res[WIDTH-1:0];
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef SIGNED_MULDIV_EN
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef SIGNED_MULDIV_EN
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
`endif
    end
  end

  // HI/LO already show the new result during the done cycle.
  assign bus.busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done = (state_q == S_FIN);
  assign bus.hi   = bus.done ? res[2*WIDTH-1:WIDTH] : hi_q;
  assign bus.lo   = bus.done ? res[WIDTH-1:0] : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_issue = 0;
  int   n_done = 0;
  exp_t exp_q[$];

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic           sgn;
    int             q, r;
`ifdef SIGNED_MULDIV_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    if (!op[0]) begin
      if (sgn) p = 64'(longint'(int'(a)) * longint'(int'(b)));
      else begin
        p = a;
        p = p * b;
      end
      return p;
    end
    if (b == '0) return {a, {W{1'b1}}};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    logic [2*W-1:0] m;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dataA = a; bus.dataB = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.dataA = $urandom; bus.dataB = $urandom;
    if (push) begin
      m = model(op, a, b);
      e.hi = m[2*W-1:W]; e.lo = m[W-1:0]; e.cyc = cyc;
      exp_q.push_back(e);
      n_issue++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) begin
      total++; bad++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic pulse_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.dataA = a; bus.dataB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got done with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
        chk("busy_in_fin", {31'b0, bus.busy}, 32'h0);
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.dataA = '0; bus.dataB = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    rst_n = 1'b1;

    issue(2'b00, 32'hFFFF_FFFF, 32'h2, 1); wait_done();
    issue(2'b01, 32'd100, 32'd7, 1);        wait_done();
    issue(2'b01, 32'd5, 32'd0, 1);          wait_done();

    // Restarts while busy are ignored; HI/LO hold the previous result meanwhile.
    issue(2'b00, 32'd3, 32'd4, 1);
    repeat (4) @(negedge clk);
    pulse_start(2'b01, 32'd9, 32'd9);
    chk("busy_mid", {31'b0, bus.busy}, 32'h1);
    chk("hold_hi", bus.hi, 32'd5);
    chk("hold_lo", bus.lo, 32'hFFFF_FFFF);
    repeat (14) @(negedge clk);
    pulse_start(2'b00, 32'd100, 32'd100);
    wait_done();
    // start during FIN is ignored too.
    pulse_start(2'b00, 32'd1, 32'd1);
    @(negedge clk);
    chk("fin_start_busy", {31'b0, bus.busy}, 32'h0);
    chk("hold_after_lo", bus.lo, 32'd12);

    // Reset in the middle of a divide aborts it.
    issue(2'b01, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_done", {31'b0, bus.done}, 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'd6, 32'd7, 1); wait_done();

`ifdef SIGNED_MULDIV_EN
    issue(2'b10, -32'sd3, 32'd5, 1);               wait_done();
    issue(2'b11, -32'sd7, 32'd2, 1);               wait_done();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done();
    issue(2'b11, -32'sd5, 32'd0, 1);               wait_done();
`endif

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      issue(2'($urandom), a, b, 1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("outstanding", 32'(exp_q.size()), 32'h0);
    chk("done_count", 32'(n_done), 32'(n_issue));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
